// File: rtl/instruction_ram.sv
// instruction_ram: runtime-loadable instruction store for the lab CPU.
// A chunk-serial loader writes a 16-bit word count followed by the
// instruction words, least-significant chunk first. Fetches return one
// registered result per cycle. Addresses outside the loaded program return
// DEFAULT_INSTR with oFault set.
module instruction_ram #(
    parameter int                     INSTR_WIDTH   = 28,
    parameter int                     ADDR_WIDTH    = 16,
    parameter int                     DEPTH         = 256,
    parameter int                     LOAD_WIDTH    = 8,
    parameter logic [INSTR_WIDTH-1:0] DEFAULT_INSTR = '0
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   iFetch,
    input  logic [ADDR_WIDTH-1:0]  iAddress,
    output logic [INSTR_WIDTH-1:0] oInstruction,
    output logic                   oInstructionValid,
    output logic                   oFault,
    input  logic                   iLoadStart,
    input  logic [LOAD_WIDTH-1:0]  iLoadData,
    input  logic                   iLoadValid,
    output logic                   oLoadReady,
    output logic                   oBusy,
    output logic                   oLoadDone,
    output logic                   oLoadError
);

    // Number of loader chunks that make up the header and one word.
    localparam int HDR_CHUNKS  = (16 + LOAD_WIDTH - 1) / LOAD_WIDTH;
    localparam int WORD_CHUNKS = (INSTR_WIDTH + LOAD_WIDTH - 1) / LOAD_WIDTH;
    localparam int MAX_CHUNKS  = (HDR_CHUNKS > WORD_CHUNKS) ? HDR_CHUNKS : WORD_CHUNKS;

    // One assembly buffer wide enough for either a header or a word.
    localparam int BUF_W  = MAX_CHUNKS * LOAD_WIDTH;
    localparam int CNT_W  = $clog2(MAX_CHUNKS + 1);
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Common width for comparing a fetch address against the 17-bit count.
    localparam int CMP_W  = (ADDR_WIDTH > 17) ? ADDR_WIDTH : 17;

    localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(HDR_CHUNKS - 1);
    localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(WORD_CHUNKS - 1);
    localparam logic [16:0]      DEPTH_C   = 17'(DEPTH);

    // Loader states.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HDR  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    // Loader control.
    logic [1:0]       state;
    logic [CNT_W-1:0] chunk_cnt;
    logic [15:0]      target_n;
    logic [16:0]      loaded_cnt;
    logic             load_done;
    logic             load_error;

    // Chunk assembly and storage (not reset; loaded_cnt masks stale data).
    logic [BUF_W-1:0]       asm_buf;
    logic [BUF_W-1:0]       asm_next;
    logic [INSTR_WIDTH-1:0] mem [0:DEPTH-1];

    // Fetch output stage.
    logic [INSTR_WIDTH-1:0] instr_p1;
    logic                   vld_p1;
    logic                   fault_p1;

    // Decoded per-cycle events.
    logic                   busy;
    logic                   chunk_acc;
    logic                   hdr_last;
    logic                   word_last;
    logic                   last_word;
    logic [15:0]            hdr_n;
    logic [INSTR_WIDTH-1:0] word_in;
    logic                   fetch_acc;
    logic                   in_range;
    logic [CMP_W-1:0]       addr_ext;
    logic [CMP_W-1:0]       cnt_ext;
    logic [MEM_AW-1:0]      rd_idx;
    logic [MEM_AW-1:0]      wr_idx;

    assign busy       = (state == S_HDR) || (state == S_DATA);
    assign oBusy      = busy;
    assign oLoadReady = busy;

    // A restart wins over a chunk presented on the same edge.
    assign chunk_acc  = iLoadValid && busy && !iLoadStart;
    assign hdr_last   = chunk_acc && (state == S_HDR)  && (chunk_cnt == HDR_LAST);
    assign word_last  = chunk_acc && (state == S_DATA) && (chunk_cnt == WORD_LAST);
    assign last_word  = (loaded_cnt + 17'd1) == {1'b0, target_n};

    // Surplus high bits of the final chunk fall outside these slices.
    assign hdr_n      = asm_next[15:0];
    assign word_in    = asm_next[INSTR_WIDTH-1:0];

    // The write address always equals the number of words already stored.
    assign wr_idx     = MEM_AW'(loaded_cnt);

    assign fetch_acc  = iFetch && !busy;
    assign addr_ext   = CMP_W'(iAddress);
    assign cnt_ext    = CMP_W'(loaded_cnt);
    assign in_range   = addr_ext < cnt_ext;
    assign rd_idx     = MEM_AW'(iAddress);

    assign oInstruction      = instr_p1;
    assign oInstructionValid = vld_p1;
    assign oFault            = fault_p1;
    assign oLoadDone         = load_done;
    assign oLoadError        = load_error;

    // Merge the incoming chunk into its slot of the assembly buffer.
    always_comb begin
        asm_next = asm_buf;
        for (int i = 0; i < MAX_CHUNKS; i++) begin
            if (chunk_cnt == CNT_W'(i)) begin
                asm_next[i*LOAD_WIDTH +: LOAD_WIDTH] = iLoadData;
            end
        end
    end

    // Assembly buffer and instruction storage writes.
    always_ff @(posedge Clock) begin
        if (chunk_acc) begin
            asm_buf <= asm_next;
        end
        if (word_last) begin
            mem[wr_idx] <= word_in;
        end
    end

    // Loader state machine: header collection, word counting, abort and error.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= S_IDLE;
            chunk_cnt  <= '0;
            target_n   <= '0;
            loaded_cnt <= '0;
            load_done  <= 1'b0;
            load_error <= 1'b0;
        end else begin
            load_done <= 1'b0;
            if (iLoadStart) begin
                state      <= S_HDR;
                chunk_cnt  <= '0;
                loaded_cnt <= '0;
                load_error <= 1'b0;
            end else begin
                case (state)
                    S_HDR: begin
                        if (hdr_last) begin
                            chunk_cnt <= '0;
                            if (hdr_n == 16'd0) begin
                                state     <= S_IDLE;
                                load_done <= 1'b1;
                            end else if ({1'b0, hdr_n} > DEPTH_C) begin
                                state      <= S_ERR;
                                load_error <= 1'b1;
                            end else begin
                                state    <= S_DATA;
                                target_n <= hdr_n;
                            end
                        end else if (chunk_acc) begin
                            chunk_cnt <= chunk_cnt + CNT_W'(1);
                        end
                    end
                    S_DATA: begin
                        if (word_last) begin
                            chunk_cnt  <= '0;
                            loaded_cnt <= loaded_cnt + 17'd1;
                            if (last_word) begin
                                state     <= S_IDLE;
                                load_done <= 1'b1;
                            end
                        end else if (chunk_acc) begin
                            chunk_cnt <= chunk_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        // IDLE and ERR only leave on iLoadStart.
                    end
                endcase
            end
        end
    end

    // Fetch stage p1: registered result, default plus fault outside the program.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            instr_p1 <= DEFAULT_INSTR;
            vld_p1   <= 1'b0;
            fault_p1 <= 1'b0;
        end else begin
            vld_p1 <= fetch_acc;
            if (fetch_acc) begin
                if (in_range) begin
                    instr_p1 <= mem[rd_idx];
                    fault_p1 <= 1'b0;
                end else begin
                    instr_p1 <= DEFAULT_INSTR;
                    fault_p1 <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/instruction_ram.md
# instruction_ram

Parametrised, runtime-loadable instruction store for the lab CPU. Replaces a hard-wired program with a synchronous RAM filled through a chunk-serial loader port: a 16-bit word count followed by the instruction words. Fetches have one-cycle latency. Any address not covered by the loaded program returns a configurable default instruction.

## Interface
- INSTR_WIDTH, 28: instruction word width.
- ADDR_WIDTH, 16: fetch address width.
- DEPTH, 256: number of storage words, 1..65535.
- LOAD_WIDTH, 8: loader chunk width, 1..16.
- DEFAULT_INSTR, 28'h0: value returned for unloaded or out-of-range addresses.
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high reset.
- iFetch  in  1  fetch request, sampled on the rising edge.
- iAddress  in  ADDR_WIDTH  fetch address, sampled together with iFetch.
- oInstruction  out  INSTR_WIDTH  registered fetch result.
- oInstructionValid  out  1  one-cycle pulse; oInstruction is the result of a fetch.
- oFault  out  1  registered with oInstruction; set when the fetched address is at or above the loaded count.
- iLoadStart  in  1  begin or restart a program load.
- iLoadData  in  LOAD_WIDTH  loader chunk.
- iLoadValid  in  1  loader chunk present.
- oLoadReady  out  1  block accepts a chunk.
- oBusy  out  1  load in progress; fetches are ignored.
- oLoadDone  out  1  one-cycle pulse when a load completes.
- oLoadError  out  1  level; the last load requested a count greater than DEPTH.

## Operation
- Derived values:
  - HDR_CHUNKS = ceil(16/LOAD_WIDTH).
  - WORD_CHUNKS = ceil(INSTR_WIDTH/LOAD_WIDTH).
  - Chunks arrive least-significant first.
  - Surplus high bits of the final chunk are ignored.
- A chunk is accepted on a rising edge where iLoadValid && oLoadReady. Gaps in iLoadValid are legal.
- State IDLE:
  - oBusy=0, oLoadReady=0.
  - Fetches are served.
  - iLoadStart: loadedCount:=0, oLoadError:=0, go to HDR.
- State HDR:
  - oBusy=1, oLoadReady=1.
  - Collect HDR_CHUNKS chunks into count N.
  - If N==0: go to IDLE, pulse oLoadDone.
  - If N>DEPTH: go to ERR, set oLoadError=1.
  - Otherwise: go to DATA with writeAddr=0.
- State DATA:
  - oBusy=1, oLoadReady=1.
  - Assemble WORD_CHUNKS chunks.
  - On the final chunk: write mem[writeAddr], writeAddr++, loadedCount++.
  - After word N: go to IDLE and pulse oLoadDone in the same edge.
- State ERR:
  - oBusy=0, oLoadReady=0.
  - loadedCount=0, so fetches return the default with oFault=1.
  - Leave only on iLoadStart (go to HDR).
- iLoadStart in HDR or DATA aborts the current load:
  - loadedCount:=0, chunk counters cleared, go to HDR.
  - A chunk accepted on the same edge is discarded.
- Fetch result:
  - If iAddress < loadedCount: oInstruction=mem[iAddress], oFault=0.
  - Otherwise: oInstruction=DEFAULT_INSTR, oFault=1.
  - This includes iAddress ≥ DEPTH.
- Fetches while oBusy=1 are dropped: no oInstructionValid, and oInstruction holds its value.
- With no fetch, oInstruction holds and oInstructionValid=0.
- Memory contents are not reset. loadedCount=0 masks them.

## Timing
- Reset values:
  - state IDLE, loadedCount=0.
  - oInstruction=DEFAULT_INSTR.
  - oInstructionValid, oFault, oLoadReady, oBusy, oLoadDone, oLoadError all 0.
- Reset mid-load returns to IDLE with an empty program.
- Fetch latency: iFetch sampled at edge k gives oInstruction/oInstructionValid/oFault valid after edge k+1. Back-to-back fetches give one result per cycle.
- iLoadStart at edge k: oBusy and oLoadReady are high after edge k, and the first chunk can be accepted at edge k+1.
- A word written at edge k is fetchable from edge k+1 onward, once IDLE is reached.
- The last accepted chunk at edge k gives oLoadDone=1, oBusy=0 and oLoadReady=0 for the cycle after edge k. A fetch is accepted at edge k+1.
- Minimum load time: 1 + HDR_CHUNKS + N·WORD_CHUNKS cycles.

## Test plan
- Reset then fetch address 0 → oInstruction=0, oFault=1, oInstructionValid pulse one cycle after the fetch.
- Load N=3 (chunks 03,00) with words 28'h1234567 (67,45,23,01), 28'hABCDEF0, 28'h0000001, then fetch 0,1,2,3 back-to-back → 1234567, ABCDEF0, 0000001 with oFault=0, then DEFAULT_INSTR with oFault=1. oLoadDone pulses exactly once.
- The same load with iLoadValid toggling every other cycle → identical memory contents; oBusy stays 1 throughout; fetches issued during the load produce no oInstructionValid.
- Header N=300 with DEPTH=256 → oLoadError=1, state ERR, fetch 0 returns the default with oFault=1; a following valid load clears oLoadError.
- iLoadStart after 1.5 words of a 3-word load, then a complete 2-word load → only the new 2 words are fetchable; address 2 faults.
- Header N=0 → oLoadDone one cycle after the second header chunk, and every fetch faults.
